uart_frame_seq: RTL and testbench

UART_FRAME_SEQ -- requirements
Module: uart_frame_seq

---
 rtl/uart_frame_seq_pkg.sv | 39 +++
 rtl/uart_frame_seq.sv | 162 ++++++++++++++++
 tb/tb_uart_frame_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_seq_pkg
// Function : Shared constants and types for the UART frame sequencer:
//            field select codes, frame length and FSM state encoding.
//            Optional feature macro: UART_FRAME_CHECKSUM_EN
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_seq_pkg;

  // Field select codes presented to the external field mux
  localparam logic [3:0] SEL_PL1_POSX   = 4'h1;
  localparam logic [3:0] SEL_PL1_POSY   = 4'h2;
  localparam logic [3:0] SEL_PL2_POSX   = 4'h3;
  localparam logic [3:0] SEL_PL2_POSY   = 4'h4;
  localparam logic [3:0] SEL_BALL_POSX  = 4'h5;
  localparam logic [3:0] SEL_BALL_POSY  = 4'h6;
  localparam logic [3:0] SEL_MATCH_CTRL = 4'h7;

  // Words per frame for the default select range
  localparam int FRAME_WORDS = 7;

  // Sequencer states; CSUM exists only when the checksum byte is enabled
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_SEND_LO = 3'd4,
`ifdef UART_FRAME_CHECKSUM_EN
    ST_NEXT    = 3'd5,
    ST_CSUM    = 3'd6
`else
    ST_NEXT    = 3'd5
`endif
  } state_t;

endpackage : uart_frame_seq_pkg
`default_nettype wire

// File: rtl/uart_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_seq
// Function : Walks the field select code from FIRST_SEL to LAST_SEL, waits
//            for the external mux to settle, captures each 16-bit word and
//            streams it high byte first over a valid/ready byte interface.
//            Optional feature macro: UART_FRAME_CHECKSUM_EN appends an XOR
//            checksum byte of all data bytes sent in the frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_seq
  import uart_frame_seq_pkg::*;
#(
  parameter logic [3:0] FIRST_SEL = 4'h1,
  parameter logic [3:0] LAST_SEL  = 4'h7,
  parameter int         SETTLE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [15:0] data,
  output logic [3:0]  sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_drop
);

  // Settle counter sized for SETTLE-1; a SETTLE of 0 behaves like 1
  localparam int              CNT_W       = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);

  state_t           state_q;
  logic [CNT_W-1:0] settle_q;
  logic [15:0]      hold_q;
  logic [3:0]       sel_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             frame_drop_q;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  // Handshake only possible while a byte is offered, so stray ready is ignored
  logic w_accept;
  assign w_accept = tx_valid_q && tx_ready;

  // Frame sequencer: state, settle counter, holding register and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      hold_q       <= 16'h0000;
      sel_q        <= 4'h0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_drop_q <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      // A request arriving while busy is discarded and flagged one cycle later
      frame_drop_q <= frame_start && busy_q;

      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            sel_q    <= FIRST_SEL;
            settle_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SETTLE;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
          end
        end

        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= ST_LOAD;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        ST_LOAD: begin
          hold_q     <= data;
          tx_data_q  <= data[15:8];
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND_HI;
        end

        ST_SEND_HI: begin
          if (w_accept) begin
            tx_data_q <= hold_q[7:0];
            state_q   <= ST_SEND_LO;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q    <= csum_q ^ tx_data_q;
`endif
          end else begin
            // Re-asserting the captured high byte keeps it stable during stalls
            tx_data_q <= hold_q[15:8];
          end
        end

        ST_SEND_LO: begin
          if (w_accept) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_NEXT;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q     <= csum_q ^ tx_data_q;
`endif
          end
        end

        ST_NEXT: begin
          if (sel_q == LAST_SEL) begin
`ifdef UART_FRAME_CHECKSUM_EN
            tx_data_q  <= csum_q;
            tx_valid_q <= 1'b1;
            state_q    <= ST_CSUM;
`else
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
`endif
          end else begin
            sel_q    <= sel_q + 4'h1;
            settle_q <= '0;
            state_q  <= ST_SETTLE;
          end
        end

`ifdef UART_FRAME_CHECKSUM_EN
        ST_CSUM: begin
          if (w_accept) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
`endif

        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_drop = frame_drop_q;

endmodule : uart_frame_seq
`default_nettype wire

// File: tb/tb_uart_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_seq
// Function : Self-checking bench for uart_frame_seq with a registered field
//            mux model, random backpressure and a frame-level byte model.
//            Honours UART_FRAME_CHECKSUM_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_seq;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [15:0] data;
  logic [3:0]  sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_drop;

  int          total = 0;
  int          bad   = 0;
  bq_t         got;
  logic [11:0] pay [16];
  logic [15:0] data_next;
  int          rdy_mode;
  logic        rdy_val;
  int          drops;

  always #5 clk = ~clk;

  uart_frame_seq dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .data       (data),
    .sel        (sel),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_drop (frame_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream of one frame: words {sel, payload} for sel 1..7,
  // high byte first, plus optional XOR checksum of all data bytes
  function automatic bq_t model();
    bq_t         q;
    logic [15:0] w;
    byte unsigned x;
    x = 8'h00;
    for (int s = 1; s <= 7; s++) begin
      w = {4'(s), pay[s]};
      q.push_back(w[15:8]);
      q.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
    end
`ifdef UART_FRAME_CHECKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  // One clock: record the handshake that the coming edge completes, check
  // stall stability, then update the mux model and ready for the next edge
  task automatic step();
    logic       acc;
    logic       stl;
    logic [7:0] d;
    acc = tx_valid && tx_ready && !rst;
    stl = tx_valid && !tx_ready && !rst;
    d   = tx_data;
    @(negedge clk);
    if (acc) got.push_back(d);
    if (stl) begin
      chk("stall_valid", {31'd0, tx_valid}, 32'd1);
      chk("stall_data", {24'd0, tx_data}, {24'd0, d});
    end
    if (frame_drop) drops++;
    data      = data_next;
    data_next = {sel, pay[sel]};
    tx_ready  = (rdy_mode == 1) ? ($urandom_range(0, 2) == 0) : rdy_val;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic compare(input string tag);
    bq_t exp;
    exp = model();
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  task automatic start_frame();
    got.delete();
    drops       = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_sel", {28'd0, sel}, 32'd1);
  endtask

  initial begin
    int n;
    bq_t e;
    rst         = 1'b1;
    frame_start = 1'b0;
    tx_ready    = 1'b0;
    rdy_mode    = 0;
    rdy_val     = 1'b0;
    drops       = 0;
    data        = 16'h0000;
    data_next   = 16'h0000;
    for (int i = 0; i < 16; i++) pay[i] = 12'h000;
    @(negedge clk);
    repeat (3) step();

    // Reset values
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {31'd0, frame_drop}, 32'd0);
    rst = 1'b0;
    step();

    // Ready always high, fixed payload 0xABC
    for (int i = 0; i < 16; i++) pay[i] = 12'hABC;
    rdy_val = 1'b1;
    start_frame();
    wait_done("abc");
    compare("abc");
    chk("abc_sel_hold", {28'd0, sel}, 32'd7);
    chk("abc_nodrop", drops, 0);
    repeat (4) step();
    chk("idle_sel_hold", {28'd0, sel}, 32'd7);

    // Random payload, ready 1-of-3
    for (int i = 0; i < 16; i++) pay[i] = 12'($urandom);
    rdy_mode = 1;
    start_frame();
    wait_done("rnd");
    compare("rnd");

    // Mid-frame request is dropped, not queued
    for (int i = 0; i < 16; i++) pay[i] = 12'($urandom);
    start_frame();
    repeat (10) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_done("mid");
    compare("mid");
    chk("mid_drops", drops, 1);
    repeat (5) step();
    chk("mid_no_restart", {31'd0, busy}, 32'd0);

    // Reset during low byte of word 3 with the byte stalled
    rdy_mode = 0;
    rdy_val  = 1'b1;
    start_frame();
    n = 0;
    while (got.size() < 5 && n < 500) begin
      step();
      n++;
    end
    chk("rst5_reach", got.size(), 5);
    chk("rst5_sel", {28'd0, sel}, 32'd3);
    rdy_val  = 1'b0;
    tx_ready = 1'b0;
    rst      = 1'b1;
    step();
    chk("rstmid_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstmid_sel", {28'd0, sel}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    // Request together with reset is ignored
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    rst         = 1'b0;
    step();
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);
    chk("rst_start_sel", {28'd0, sel}, 32'd0);

    // Restart after reset, zero payload (checksum case), random backpressure
    for (int i = 0; i < 16; i++) pay[i] = 12'h000;
    rdy_mode = 1;
    start_frame();
    wait_done("zero");
    compare("zero");

    // Request on the same edge as the last byte acceptance is dropped
    for (int i = 0; i < 16; i++) pay[i] = 12'($urandom);
    rdy_mode = 0;
    rdy_val  = 1'b1;
    e        = model();
    start_frame();
    n = 0;
    while (!(got.size() == e.size() - 1 && tx_valid === 1'b1 && tx_ready === 1'b1) && n < 500) begin
      step();
      n++;
    end
    chk("edge_reach", got.size(), e.size() - 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_done("edge");
    repeat (4) step();
    compare("edge");
    chk("edge_drops", drops, 1);
    chk("edge_no_restart", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_frame_seq
`default_nettype wire
